// File: rtl/path_reader_if.sv
// Bundles the stack-side and consumer-side signals of path_reader.
// The slave modport is the reader itself; master is the stack/consumer side.
interface path_reader_if #(
    parameter int LOC_W = 8,
    parameter int CNT_W = 7
);
    logic             start;
    logic             stk_nonempty;
    logic [LOC_W-1:0] stk_loc;
    logic             stk_pop;
    logic [LOC_W-1:0] out_loc;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] path_len;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, stk_nonempty, stk_loc, out_ready,
        input  stk_pop, out_loc, out_valid, path_len, busy, done, overflow
    );

    modport slave (
        input  start, stk_nonempty, stk_loc, out_ready,
        output stk_pop, out_loc, out_valid, path_len, busy, done, overflow
    );
endinterface

// File: rtl/path_reader.sv
// Drains the solver's location stack (goal first) into a local buffer and
// replays it start-to-goal over a valid/ready stream.
module path_reader #(
    parameter int LOC_W = 8,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input logic          clk,
    input logic          rst,
    path_reader_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        CAP  = 3'd2,
        EMIT = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] wrCnt, wrCntNext;
    logic [CNT_W-1:0] rdIdx, rdIdxNext;
    logic [CNT_W-1:0] pathLen, pathLenNext;
    logic [CNT_W-1:0] wrInc;
    logic [AW-1:0]    rdPrev;
    logic             overflowQ, overflowNext;
    logic [LOC_W-1:0] outLocQ, outLocNext;
    logic             stkPopQ, outValidQ, busyQ, doneQ;
    logic             bufWe;
    logic [LOC_W-1:0] pathBuf [DEPTH];

    // Next-state and datapath decode; outputs are registered from stateNext.
    always_comb begin
        stateNext    = state;
        wrCntNext    = wrCnt;
        rdIdxNext    = rdIdx;
        pathLenNext  = pathLen;
        overflowNext = overflowQ;
        outLocNext   = outLocQ;
        bufWe        = 1'b0;
        wrInc        = wrCnt + CNT_W'(1);
        rdPrev       = rdIdx[AW-1:0] - AW'(1);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    pathLenNext  = '0;
                    overflowNext = 1'b0;
                    wrCntNext    = '0;
                    stateNext    = bus.stk_nonempty ? POP : FIN;
                end else begin
                    stateNext = IDLE;
                end
            end
            POP: stateNext = CAP;
            CAP: begin
                bufWe     = 1'b1;
                wrCntNext = wrInc;
                if (!bus.stk_nonempty) begin
                    pathLenNext = wrInc;
                    rdIdxNext   = wrCnt;
                    // The top word is being written this cycle, so bypass the buffer.
                    outLocNext  = bus.stk_loc;
                    stateNext   = EMIT;
                end else if (wrInc < DEPTH_C) begin
                    stateNext = POP;
                end else begin
                    overflowNext = 1'b1;
                    stateNext    = FIN;
                end
            end
            EMIT: begin
                if (!bus.out_ready) begin
                    stateNext = EMIT;
                end else if (rdIdx == '0) begin
                    stateNext = FIN;
                end else begin
                    rdIdxNext  = rdIdx - CNT_W'(1);
                    outLocNext = pathBuf[rdPrev];
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wrCnt     <= '0;
            rdIdx     <= '0;
            pathLen   <= '0;
            overflowQ <= 1'b0;
            outLocQ   <= '0;
            stkPopQ   <= 1'b0;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            wrCnt     <= wrCntNext;
            rdIdx     <= rdIdxNext;
            pathLen   <= pathLenNext;
            overflowQ <= overflowNext;
            outLocQ   <= outLocNext;
            stkPopQ   <= (stateNext == POP);
            outValidQ <= (stateNext == EMIT);
            busyQ     <= (stateNext != IDLE);
            doneQ     <= (stateNext == FIN);
        end
    end

    // Path buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (bufWe) begin
            pathBuf[wrCnt[AW-1:0]] <= bus.stk_loc;
        end
    end

    assign bus.stk_pop   = stkPopQ;
    assign bus.out_loc   = outLocQ;
    assign bus.out_valid = outValidQ;
    assign bus.path_len  = pathLen;
    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
    assign bus.overflow  = overflowQ;
endmodule

// File: tb/tb_path_reader.sv
// Scoreboard bench for path_reader: behavioural stacks feed two instances
// (DEPTH 64 and DEPTH 4); a monitor checks the stream against expected words.
module tb_path_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    path_reader_if #(.LOC_W(8), .CNT_W(7)) ifA ();
    path_reader_if #(.LOC_W(8), .CNT_W(7)) ifB ();

    path_reader #(.LOC_W(8), .DEPTH(64), .CNT_W(7)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    path_reader #(.LOC_W(8), .DEPTH(4),  .CNT_W(7)) dutB (.clk(clk), .rst(rst), .bus(ifB));

    int tests = 0;
    int fails = 0;
    logic [7:0] expQ [$];

    // Behavioural stacks (not touched by rst)
    logic [7:0] memA [16];
    logic [7:0] memB [16];
    logic [4:0] spA = 5'd0;
    logic [4:0] spB = 5'd0;
    logic       pushEnA = 1'b0, pushEnB = 1'b0;
    logic [7:0] pushDataA = 8'h00, pushDataB = 8'h00;

    assign ifA.stk_nonempty = (spA != 5'd0);
    assign ifB.stk_nonempty = (spB != 5'd0);

    always @(posedge clk) begin
        if (pushEnA) begin
            memA[spA] <= pushDataA;
            spA <= spA + 5'd1;
        end else if (ifA.stk_pop && spA != 5'd0) begin
            ifA.stk_loc <= memA[spA - 5'd1];
            spA <= spA - 5'd1;
        end
    end

    always @(posedge clk) begin
        if (pushEnB) begin
            memB[spB] <= pushDataB;
            spB <= spB + 5'd1;
        end else if (ifB.stk_pop && spB != 5'd0) begin
            ifB.stk_loc <= memB[spB - 5'd1];
            spB <= spB - 5'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: event counters and scoreboard compare
    int popCntA = 0, doneCntA = 0, validCntA = 0;
    int popCntB = 0, doneCntB = 0, validCntB = 0;
    logic prevPopA = 1'b0, prevPopB = 1'b0;

    always @(negedge clk) begin
        if (ifA.stk_pop) begin
            popCntA++;
            check("pop_gap_A", int'(prevPopA), 0);
        end
        prevPopA = ifA.stk_pop;
        if (ifA.done) doneCntA++;
        if (ifA.out_valid) validCntA++;
        if (ifA.out_valid && ifA.out_ready) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got 0x%0h expected none", ifA.out_loc);
            end else begin
                check("stream_word", int'(ifA.out_loc), int'(expQ.pop_front()));
            end
        end
        if (ifB.stk_pop) begin
            popCntB++;
            check("pop_gap_B", int'(prevPopB), 0);
        end
        prevPopB = ifB.stk_pop;
        if (ifB.done) doneCntB++;
        if (ifB.out_valid) validCntB++;
    end

    task automatic pushA(input logic [7:0] v);
        pushDataA = v;
        pushEnA = 1'b1;
        @(posedge clk); #1;
        pushEnA = 1'b0;
    endtask

    task automatic pushB(input logic [7:0] v);
        pushDataB = v;
        pushEnB = 1'b1;
        @(posedge clk); #1;
        pushEnB = 1'b0;
    endtask

    task automatic clearCounts();
        popCntA = 0; doneCntA = 0; validCntA = 0;
        popCntB = 0; doneCntB = 0; validCntB = 0;
    endtask

    task automatic pulseStartA();
        ifA.start = 1'b1;
        @(posedge clk); #1;
        ifA.start = 1'b0;
    endtask

    task automatic waitDone(input bit selB, input int maxc, input string name);
        bit got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((selB ? ifB.done : ifA.done) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(name, int'(got), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic waitValidA(input int maxc, input string name);
        bit got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (ifA.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check(name, int'(got), 1);
    endtask

    initial begin
        ifA.start = 1'b0; ifA.out_ready = 1'b1;
        ifB.start = 1'b0; ifB.out_ready = 1'b1;
        #12;
        // Reset values
        check("rst_stk_pop",  int'(ifA.stk_pop), 0);
        check("rst_valid",    int'(ifA.out_valid), 0);
        check("rst_out_loc",  int'(ifA.out_loc), 0);
        check("rst_path_len", int'(ifA.path_len), 0);
        check("rst_busy",     int'(ifA.busy), 0);
        check("rst_done",     int'(ifA.done), 0);
        check("rst_overflow", int'(ifA.overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic three-entry replay
        pushA(8'h11); pushA(8'h22); pushA(8'h33);
        expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h33);
        clearCounts();
        pulseStartA();
        check("t1_busy", int'(ifA.busy), 1);
        waitDone(1'b0, 50, "t1_done_seen");
        check("t1_pops", popCntA, 3);
        check("t1_done_cnt", doneCntA, 1);
        check("t1_path_len", int'(ifA.path_len), 3);
        check("t1_queue_left", expQ.size(), 0);
        check("t1_idle_busy", int'(ifA.busy), 0);

        // 2: empty stack
        clearCounts();
        ifA.start = 1'b1;
        @(posedge clk); #1;
        ifA.start = 1'b0;
        @(negedge clk);
        check("t2_done_hi", int'(ifA.done), 1);
        check("t2_busy_fin", int'(ifA.busy), 1);
        @(negedge clk);
        check("t2_done_lo", int'(ifA.done), 0);
        check("t2_busy_lo", int'(ifA.busy), 0);
        check("t2_pops", popCntA, 0);
        check("t2_valids", validCntA, 0);
        check("t2_path_len", int'(ifA.path_len), 0);
        @(posedge clk); #1;

        // 3: back-pressure during EMIT
        pushA(8'hA0); pushA(8'hB1);
        expQ.push_back(8'hA0); expQ.push_back(8'hB1);
        clearCounts();
        ifA.out_ready = 1'b0;
        pulseStartA();
        waitValidA(20, "t3_valid_seen");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", int'(ifA.out_valid), 1);
            check("t3_hold_loc", int'(ifA.out_loc), 32'hA0);
        end
        @(posedge clk); #1;
        ifA.out_ready = 1'b1;
        waitDone(1'b0, 20, "t3_done_seen");
        check("t3_queue_left", expQ.size(), 0);
        check("t3_path_len", int'(ifA.path_len), 2);
        check("t3_done_cnt", doneCntA, 1);

        // 4: overflow on the DEPTH=4 instance
        for (int i = 0; i < 6; i++) pushB(8'(8'h40 + i));
        clearCounts();
        ifB.start = 1'b1;
        @(posedge clk); #1;
        ifB.start = 1'b0;
        waitDone(1'b1, 40, "t4_done_seen");
        check("t4_pops", popCntB, 4);
        check("t4_overflow", int'(ifB.overflow), 1);
        check("t4_valids", validCntB, 0);
        check("t4_stack_left", int'(spB), 2);
        check("t4_path_len", int'(ifB.path_len), 0);
        check("t4_done_cnt", doneCntB, 1);

        // 5: reset during EMIT after two accepted words
        for (int i = 1; i <= 5; i++) pushA(8'(i));
        expQ.push_back(8'h01); expQ.push_back(8'h02);
        clearCounts();
        ifA.out_ready = 1'b0;
        pulseStartA();
        waitValidA(30, "t5_valid_seen");
        ifA.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifA.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_rst_pop",   int'(ifA.stk_pop), 0);
        check("t5_rst_valid", int'(ifA.out_valid), 0);
        check("t5_rst_loc",   int'(ifA.out_loc), 0);
        check("t5_rst_busy",  int'(ifA.busy), 0);
        check("t5_rst_len",   int'(ifA.path_len), 0);
        check("t5_queue_left", expQ.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ifA.out_ready = 1'b1;
        @(posedge clk); #1;
        clearCounts();
        pulseStartA();
        waitDone(1'b0, 10, "t5_done_seen");
        check("t5_valids", validCntA, 0);
        check("t5_pops", popCntA, 0);
        check("t5_path_len", int'(ifA.path_len), 0);

        // 6: start re-asserted in POP and in EMIT is ignored
        pushA(8'h07); pushA(8'h08); pushA(8'h09);
        expQ.push_back(8'h07); expQ.push_back(8'h08); expQ.push_back(8'h09);
        clearCounts();
        ifA.out_ready = 1'b0;
        ifA.start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifA.start = 1'b0;
        waitValidA(20, "t6_valid_seen");
        ifA.start = 1'b1;
        @(posedge clk); #1;
        ifA.start = 1'b0;
        ifA.out_ready = 1'b1;
        waitDone(1'b0, 20, "t6_done_seen");
        repeat (10) @(posedge clk);
        #1;
        check("t6_pops", popCntA, 3);
        check("t6_done_cnt", doneCntA, 1);
        check("t6_path_len", int'(ifA.path_len), 3);
        check("t6_queue_left", expQ.size(), 0);
        check("t6_busy", int'(ifA.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
